// File: rtl/mbgd_pkg.sv
// Shared definitions for the mini-batch gradient-descent controllers:
// sequencer state encoding and default datapath dimensions.
package mbgd_pkg;

  localparam int DEF_FW  = 3;
  localparam int DEF_IW  = 8;
  localparam int DEF_LAT = 8;
  localparam int DEF_CW  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mbgd_phase2_sequencer_if.sv
// Handshake, configuration and memory-control bundle between the training FSM,
// the phase-2 sequencer and the phase-2 datapath / theta register file.
interface mbgd_phase2_sequencer_if
  import mbgd_pkg::*;
#(
  parameter int FW = DEF_FW,
  parameter int IW = DEF_IW
);

  logic          start;
  logic          abort;
  logic [FW:0]   cfg_num_feat;
  logic [IW-1:0] cfg_num_iter;
  logic          p2_enable;
  logic [FW-1:0] col_idx;
  logic          teta_wr_en;
  logic [FW-1:0] teta_wr_addr;
  logic [IW-1:0] iter_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, cfg_num_feat, cfg_num_iter,
    input  p2_enable, col_idx, teta_wr_en, teta_wr_addr, iter_idx, busy, done
  );

  modport slave (
    input  start, abort, cfg_num_feat, cfg_num_iter,
    output p2_enable, col_idx, teta_wr_en, teta_wr_addr, iter_idx, busy, done
  );

endinterface

// File: rtl/mbgd_lat_counter.sv
// Loadable up-counter that flags when it reaches LAT-1; used to time the
// enable window of a fixed-latency datapath.
module mbgd_lat_counter
  import mbgd_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int LAT = DEF_LAT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CW'(LAT - 1));

endmodule

// File: rtl/mbgd_phase2_sequencer.sv
// Phase-2 theta-update sequencer: walks every feature column for the
// programmed number of iterations, windowing the datapath enable per column.
module mbgd_phase2_sequencer
  import mbgd_pkg::*;
#(
  parameter int FW  = DEF_FW,
  parameter int IW  = DEF_IW,
  parameter int LAT = DEF_LAT,
  parameter int CW  = DEF_CW
) (
  input  logic                     clk,
  input  logic                     resetn,
  mbgd_phase2_sequencer_if.slave   bus
);

  seq_state_e    state_q, state_d;
  logic [FW:0]   feat_q, feat_d;
  logic [IW-1:0] niter_q, niter_d;
  logic [FW-1:0] col_q, col_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          p2_q, p2_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic lat_clr, lat_load, lat_en, lat_tc;

  mbgd_lat_counter #(
    .CW  (CW),
    .LAT (LAT)
  ) u_lat (
    .clk        (clk),
    .resetn     (resetn),
    .clr_i      (lat_clr),
    .load_i     (lat_load),
    .load_val_i (CW'(1)),
    .en_i       (lat_en),
    .tc_o       (lat_tc)
  );

  always_comb begin
    state_d  = state_q;
    feat_d   = feat_q;
    niter_d  = niter_q;
    col_d    = col_q;
    iter_d   = iter_q;
    lat_clr  = 1'b0;
    lat_load = 1'b0;
    lat_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lat_clr = 1'b1;
        if (bus.start && !bus.abort) begin
          feat_d  = bus.cfg_num_feat;
          niter_d = bus.cfg_num_iter;
          col_d   = '0;
          iter_d  = '0;
          if (bus.cfg_num_feat == '0 || bus.cfg_num_iter == '0) state_d = ST_DONE;
          else                                                  state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        lat_en = 1'b1;
        if (lat_tc) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        lat_clr = 1'b1;
        // Column compare is one bit wider so a full 2^FW feature set never wraps.
        if (({1'b0, col_q} + (FW+1)'(1)) < feat_q) begin
          col_d   = col_q + FW'(1);
          state_d = ST_ISSUE;
        end else if (iter_q < (niter_q - IW'(1))) begin
          col_d   = '0;
          iter_d  = iter_q + IW'(1);
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        col_d   = '0;
        iter_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        col_d   = '0;
        iter_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (bus.abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      col_d    = '0;
      iter_d   = '0;
      lat_clr  = 1'b1;
      lat_load = 1'b0;
      lat_en   = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    p2_d   = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    wr_d   = (state_d == ST_WRITE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      feat_q  <= '0;
      niter_q <= '0;
      col_q   <= '0;
      iter_q  <= '0;
      p2_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      niter_q <= niter_d;
      col_q   <= col_d;
      iter_q  <= iter_d;
      p2_q    <= p2_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.p2_enable    = p2_q;
  assign bus.teta_wr_en   = wr_q;
  assign bus.col_idx      = col_q;
  assign bus.teta_wr_addr = col_q;
  assign bus.iter_idx     = iter_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_mbgd_phase2_sequencer.sv
// Bench for the phase-2 sequencer: directed scenarios plus randomized runs,
// every cycle compared against a schedule-based reference model.
module tb_mbgd_phase2_sequencer;
  import mbgd_pkg::*;

  localparam int FW  = 3;
  localparam int IW  = 8;
  localparam int LAT = 8;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mbgd_phase2_sequencer_if #(.FW(FW), .IW(IW)) bus ();

  mbgd_phase2_sequencer #(.FW(FW), .IW(IW), .LAT(LAT), .CW(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a run is a timeline t = 1..m_end after the start edge.
  int m_act = 0, m_t = 0, m_f = 0, m_i = 0, m_end = 0;
  int cyc = 0, wr_cnt = 0, p2_cnt = 0, done_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] dut_outs();
    return {bus.busy, bus.done, bus.p2_enable, bus.teta_wr_en,
            bus.col_idx, bus.teta_wr_addr, bus.iter_idx};
  endfunction

  function automatic logic [17:0] exp_outs();
    logic b, d, p, w;
    logic [FW-1:0] c;
    logic [IW-1:0] it;
    int k, ph;
    b = 0; d = 0; p = 0; w = 0; c = '0; it = '0;
    if (m_act != 0) begin
      b = 1;
      if (m_f * m_i == 0) begin
        d = 1;
      end else if (m_t == m_end) begin
        d  = 1;
        c  = FW'(m_f - 1);
        it = IW'(m_i - 1);
      end else begin
        k  = (m_t - 1) / (LAT + 1);
        ph = (m_t - 1) % (LAT + 1);
        p  = (ph < LAT);
        w  = (ph == LAT);
        c  = FW'(k % m_f);
        it = IW'(k / m_f);
      end
    end
    return {b, d, p, w, c, c, it};
  endfunction

  task automatic model_edge(input logic st, input logic ab);
    int tot;
    if (m_act != 0) begin
      if (ab) m_act = 0;
      else begin
        m_t++;
        if (m_t > m_end) m_act = 0;
      end
    end else if (st && !ab) begin
      m_f   = int'(bus.cfg_num_feat);
      m_i   = int'(bus.cfg_num_iter);
      tot   = m_f * m_i;
      m_end = (tot == 0) ? 1 : tot * (LAT + 1) + 1;
      m_act = 1;
      m_t   = 1;
    end
  endtask

  task automatic step(input logic st, input logic ab);
    @(negedge clk);
    bus.start = st;
    bus.abort = ab;
    @(posedge clk);
    model_edge(st, ab);
    #1;
    cyc++;
    chk($sformatf("outs@%0d", cyc), 32'(dut_outs()), 32'(exp_outs()));
    if (bus.teta_wr_en) wr_cnt++;
    if (bus.p2_enable)  p2_cnt++;
    if (bus.done)       done_cyc = cyc;
  endtask

  task automatic begin_run(input int f, input int i);
    bus.cfg_num_feat = (FW+1)'(f);
    bus.cfg_num_iter = IW'(i);
    cyc = 0; wr_cnt = 0; p2_cnt = 0; done_cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_num_feat = '0;
    bus.cfg_num_iter = '0;

    repeat (3) @(posedge clk);
    #1 chk("reset_outs", 32'(dut_outs()), 32'd0);
    @(negedge clk) resetn = 1'b1;
    repeat (2) step(0, 0);

    // F=3, I=2 nominal run
    begin_run(3, 2);
    step(1, 0);
    repeat (60) step(0, 0);
    chk("t1_wr_cnt", wr_cnt, 6);
    chk("t1_p2_cnt", p2_cnt, 48);
    chk("t1_done_cyc", done_cyc, 55);

    // zero features
    begin_run(0, 5);
    step(1, 0);
    repeat (5) step(0, 0);
    chk("t3_done_cyc", done_cyc, 1);
    chk("t3_wr_cnt", wr_cnt, 0);
    chk("t3_p2_cnt", p2_cnt, 0);

    // abort in WAIT, then restart
    begin_run(2, 1);
    step(1, 0);
    repeat (4) step(0, 0);
    step(0, 1);
    chk("t4_busy_after_abort", bus.busy, 1'b0);
    repeat (4) step(0, 0);
    chk("t4_wr_cnt", wr_cnt, 0);
    chk("t4_no_done", done_cyc, -1);
    step(1, 0);
    chk("t4_restart_col", bus.col_idx, 3'd0);
    repeat (25) step(0, 0);
    chk("t4_restart_wr_cnt", wr_cnt, 2);

    // start together with abort in IDLE
    step(1, 1);
    chk("idle_abort_start_busy", bus.busy, 1'b0);
    step(0, 0);

    // start re-pulse and config change mid-run
    begin_run(3, 2);
    step(1, 0);
    repeat (14) step(0, 0);
    bus.cfg_num_feat = 4'd7;
    step(1, 0);
    repeat (50) step(0, 0);
    chk("t5_wr_cnt", wr_cnt, 6);
    chk("t5_done_cyc", done_cyc, 55);

    // asynchronous reset mid-WAIT
    begin_run(3, 2);
    step(1, 0);
    repeat (4) step(0, 0);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk("t6_async_outs", 32'(dut_outs()), 32'd0);
    m_act = 0;
    @(negedge clk) resetn = 1'b1;
    repeat (5) step(0, 0);
    chk("t6_idle_busy", bus.busy, 1'b0);
    begin_run(1, 1);
    step(1, 0);
    repeat (12) step(0, 0);
    chk("t6_rerun_wr_cnt", wr_cnt, 1);

    // randomized runs with sporadic aborts, start re-pulses and config churn
    for (int r = 0; r < 12; r++) begin
      begin_run(int'($urandom_range(0, 8)), int'($urandom_range(0, 3)));
      step(1, 0);
      for (int c = 0; c < 300 && m_act != 0; c++) begin
        if ($urandom_range(0, 29) == 0) begin
          bus.cfg_num_feat = (FW+1)'($urandom_range(0, 8));
          bus.cfg_num_iter = IW'($urandom_range(0, 3));
        end
        step(logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 149) == 0));
      end
      repeat (2) step(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mbgd_phase2_sequencer.md
Name: mbgd_phase2_sequencer

Overview:
Controller that runs the phase-2 theta-update datapath over every feature column for a programmed number of iterations. For each column it:
- presents the column index to the x-column and theta memories,
- holds the datapath enable for the fixed pipeline latency,
- issues a single theta write-back strobe.

It sits between the top-level training FSM (start/done handshake) and the phase-2 datapath plus theta register file.

Parameters:
FW, 3, width of feature/column index (max features 2^FW)
IW, 8, width of iteration counter
LAT, 8, phase-2 pipeline latency in clk cycles from enable assertion to valid teta (>=2)
CW, 4, width of internal latency counter (2^CW > LAT)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
start  in  1  begin run; sampled only in IDLE
abort  in  1  terminate run; highest priority, any state
cfg_num_feat  in  FW+1  number of feature columns F (0..2^FW)
cfg_num_iter  in  IW  number of iterations I
p2_enable  out  1  enable to phase-2 datapath
col_idx  out  FW  current column; drives x_col memory and teta_rd_addr
teta_wr_en  out  1  one-cycle write strobe for theta register file
teta_wr_addr  out  FW  write address (equals col_idx)
iter_idx  out  IW  current iteration number
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE, ISSUE, WAIT, WRITE, DONE. All outputs are registered.
- IDLE:
  - On start=1, latch cfg_num_feat and cfg_num_iter into shadow registers.
  - If either latched value is 0, go to DONE; otherwise go to ISSUE with col_idx=0 and iter_idx=0.
  - Config changes during a run have no effect.
- ISSUE: p2_enable=1 and lat_cnt=1; go to WAIT.
- WAIT:
  - p2_enable=1; lat_cnt increments each cycle.
  - When lat_cnt==LAT-1, go to WRITE. p2_enable is therefore high for exactly LAT consecutive cycles per column.
- WRITE:
  - p2_enable=0, teta_wr_en=1, teta_wr_addr=col_idx.
  - Next-state decision:
    - col_idx<F-1: col_idx+1, go to ISSUE.
    - Else if iter_idx<I-1: col_idx=0, iter_idx+1, go to ISSUE.
    - Else: go to DONE.
- DONE: done=1 and busy=1 for one cycle; then IDLE, with col_idx and iter_idx cleared.
- Cycle cost is LAT+1 per column. A run asserts start in cycle 0, gives the first teta_wr_en in cycle LAT+1, and gives done in cycle F*I*(LAT+1)+1.
- start while busy is ignored.
- abort=1 in any non-IDLE state:
  - next cycle is IDLE with p2_enable=0, teta_wr_en=0, counters cleared, and no done pulse;
  - abort in the WRITE cycle still lets that cycle's strobe (already registered) complete;
  - abort and start together in IDLE: abort wins, stay IDLE.
- Asynchronous reset mid-run forces IDLE and zeros all outputs immediately.
- Counter rules:
  - col_idx wraps only via the explicit compare against F-1; never by overflow.
  - F=2^FW is legal; the compare is done at FW+1 bits.

Decomposition:
- Shared package mbgd_pkg: state encoding (IDLE, ISSUE, WAIT, WRITE, DONE), default FW/IW/LAT constants shared with the phase-2 datapath.
- One sub-module: mbgd_lat_counter, a loadable up-counter with a terminal-count flag at LAT-1, reused by later phase controllers.

Test Plan:
1. F=3, I=2, LAT=8, start pulse at cycle 0:
   - six teta_wr_en pulses at cycles 9,18,27,36,45,54 with addresses 0,1,2,0,1,2;
   - iter_idx 0,0,0,1,1,1;
   - done at cycle 55; busy low at cycle 56.
2. For every column in test 1, p2_enable is high for exactly 8 consecutive cycles and is low during each WRITE cycle.
3. F=0, I=5: done pulse at cycle 1; no p2_enable and no teta_wr_en ever.
4. F=2, I=1, abort asserted at cycle 5 (WAIT): p2_enable and busy are 0 from cycle 6, no teta_wr_en, no done; a new start at cycle 10 restarts from col_idx=0.
5. Start re-pulsed and cfg_num_feat changed to 7 mid-run of test 1: no effect; identical write sequence and done at cycle 55.
6. resetn deasserted asynchronously mid-WAIT: all outputs 0 immediately; after release the block stays IDLE until the next start.
